// File: rtl/video_speed_ctrl.sv
// Video-mode / CPU-speed control register with debounced hotkeys and a
// req/ack speed-change handshake toward the clock generator.
module video_speed_ctrl #(
  parameter logic [7:0]  REG_ADDR    = 8'h0B,
  parameter logic [15:0] PORT_ADDR   = 16'h8E3B,
  parameter logic [7:0]  INIT_VALUE  = 8'h00,
  parameter int          NUM_FREQ    = 8,
  parameter logic [3:0]  BOOST_SPEED = 4'd3,
  parameter int          DEBOUNCE    = 16,
  parameter bit          HAS_VGA     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  zxuno_addr,
  input  logic        zxuno_regrd,
  input  logic        zxuno_regwr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        oe,
  input  logic        kbd_change_video,
  input  logic        kbd_cycle_freq,
  input  logic        kbd_turbo_boost,
  input  logic        turbo_boost_allowed,
  output logic        vga_enable,
  output logic        scanlines_enable,
  output logic        csync_option,
  output logic [2:0]  freq_option,
  output logic        speed_req,
  output logic [3:0]  speed_next,
  input  logic        speed_ack,
  output logic [3:0]  cpu_speed
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam int          CW        = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [2:0]  FREQ_LAST = 3'(NUM_FREQ - 1);
  localparam logic [3:0]  INIT_SPD  = {2'b00, INIT_VALUE[7:6]};

  // Hotkey index: 0 = change video, 1 = cycle freq, 2 = turbo boost
  logic [2:0]    key_raw;
  logic [2:0]    key_event;
  logic          stable_q [3];
  logic [CW-1:0] cnt_q    [3];

  assign key_raw = {kbd_turbo_boost, kbd_cycle_freq, kbd_change_video};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_debounce
      always_ff @(posedge clk) begin
        if (rst) begin
          stable_q[gi] <= 1'b0;
          cnt_q[gi]    <= '0;
        end else if (key_raw[gi] == stable_q[gi]) begin
          cnt_q[gi] <= '0;
        end else if (cnt_q[gi] == DB_LAST) begin
          stable_q[gi] <= key_raw[gi];
          cnt_q[gi]    <= '0;
        end else begin
          cnt_q[gi] <= cnt_q[gi] + 1'b1;
        end
      end
      // Pulse in the same cycle the stable level is about to rise
      assign key_event[gi] = key_raw[gi] & ~stable_q[gi] & (cnt_q[gi] == DB_LAST);
    end
  endgenerate

  logic [7:0] ctl_q, ctl_d;
  logic [3:0] target_q, target_d;
  logic       boost_q, boost_d;
  logic       zx_wr, port_wr, zx_rd, port_rd;

  assign zx_wr   = zxuno_regwr && (zxuno_addr == REG_ADDR);
  assign port_wr = !iorq_n && !wr_n && (a == PORT_ADDR) && (din[7:4] == 4'h0);
  assign zx_rd   = zxuno_regrd && (zxuno_addr == REG_ADDR);
  assign port_rd = !iorq_n && !rd_n && (a == PORT_ADDR);

  always_comb begin
    ctl_d    = ctl_q;
    target_d = target_q;
    if (zx_wr) begin
      ctl_d    = din;
      target_d = {2'b00, din[7:6]};
    end else if (port_wr) begin
      ctl_d[7:6] = din[1:0];
      target_d   = din[3:0];
    end else if (key_event[0]) begin
      ctl_d[0]   = ~ctl_q[0];
      ctl_d[4:2] = ctl_q[0] ? 3'b000 : 3'b111;
    end else if (key_event[1]) begin
      ctl_d[4:2] = (ctl_q[4:2] >= FREQ_LAST) ? 3'b000 : ctl_q[4:2] + 3'd1;
    end
  end

  assign boost_d = turbo_boost_allowed ? stable_q[2] : boost_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q    <= INIT_VALUE;
      target_q <= INIT_SPD;
      boost_q  <= 1'b0;
    end else begin
      ctl_q    <= ctl_d;
      target_q <= target_d;
      boost_q  <= boost_d;
    end
  end

  // Speed handshake: the requested code is frozen until the clock generator acks
  state_t     state_q, state_d;
  logic       req_q, req_d;
  logic [3:0] next_q, next_d;
  logic [3:0] cpu_q, cpu_d;
  logic [3:0] eff;

  assign eff = boost_q ? BOOST_SPEED : target_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    next_d  = next_q;
    cpu_d   = cpu_q;
    case (state_q)
      S_IDLE: begin
        if (eff != cpu_q) begin
          next_d  = eff;
          req_d   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (speed_ack) begin
          cpu_d   = next_q;
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      next_q  <= INIT_SPD;
      cpu_q   <= INIT_SPD;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      next_q  <= next_d;
      cpu_q   <= cpu_d;
    end
  end

  // Read mux; the ZXUNO register takes precedence over the I/O port
  always_comb begin
    oe   = 1'b0;
    dout = 8'hFF;
    if (zx_rd) begin
      oe   = 1'b1;
      dout = boost_q ? {2'b11, ctl_q[5:0]} : ctl_q;
    end else if (port_rd) begin
      oe   = 1'b1;
      dout = boost_q ? {4'h0, BOOST_SPEED} : {4'h0, target_q};
    end
  end

  assign vga_enable       = HAS_VGA ? ctl_q[0] : 1'b0;
  assign scanlines_enable = HAS_VGA ? ctl_q[1] : 1'b0;
  assign freq_option      = ctl_q[4:2];
  assign csync_option     = ctl_q[5];
  assign speed_req        = req_q;
  assign speed_next       = next_q;
  assign cpu_speed        = cpu_q;

endmodule
